mem_access_ctrl: RTL
====================

# mem_access_ctrl

Data-memory access controller for the MEM stage of the pipelined MIPS core. It takes one load/store request per instruction and drives a variable-latency data memory through a request/ready handshake. It aligns store data and generates byte enables, and stalls the pipeline until the access completes. It hands the raw read word plus the access type and the low address bits to the WB-stage load-extension logic, which performs the sign/zero extension.

## Interface
Parameters:
- none; access-type encodings come from head.v (`L_S_B`, `L_S_H`, `L_S_W`, `L_S_BU`, `L_S_HU`).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM-stage instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  access size/sign, head.v L_S_* encoding.
- req_addr  in  32  byte address from the ALU.
- req_wdata  in  32  store data, right-justified.
- flush  in  1  kill the MEM-stage instruction.
- stall  out  1  freeze IF..MEM; combinational.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  memory write.
- dm_be  out  4  byte enables.
- dm_addr  out  30  word address (req_addr[31:2]).
- dm_wdata  out  32  lane-replicated store data.
- dm_ready  in  1  memory completes the access this cycle.
- dm_rdata  in  32  read word, valid with dm_ready.
- wb_valid  out  1  one-cycle completion pulse.
- wb_rdata  out  32  raw read word for load extension.
- wb_type  out  3  latched req_type.
- wb_addr_lo  out  2  latched req_addr[1:0].
- exc_valid  out  1  address-error pulse; present only with the macro.
- exc_code  out  5  4 = AdEL, 5 = AdES.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req_valid && !flush: latch the request, drive stall=1, go to BUSY.
  - If flush is asserted: no acceptance and stall=0.
- BUSY:
  - dm_req=1 and stall=1.
  - On dm_ready: capture dm_rdata into wb_rdata (loads only; stores leave it unchanged), go to RESP.
  - flush is ignored in BUSY; the access always completes.
- RESP:
  - stall=0 and wb_valid=1.
  - The pipeline advances at the end of this cycle.
  - req_valid is ignored here, because it is still the same instruction.
  - Next state is always IDLE.
- Byte lanes:
  - Store byte (`L_S_B`): dm_be = 4'b0001 << addr[1:0]; dm_wdata = {4{wdata[7:0]}}.
  - Store half (`L_S_H`): dm_be = addr[1] ? 4'b1100 : 4'b0011; dm_wdata = {2{wdata[15:0]}}.
  - Store word: dm_be = 4'b1111; dm_wdata = wdata.
  - Any load: dm_be = 4'b1111; dm_wdata = 0.
  - Store with an unlisted req_type: dm_be = 4'b0000. The handshake still runs, with no write.
- wb_type and wb_addr_lo are latched at acceptance.
- wb_rdata, wb_type and wb_addr_lo hold their values until the next acceptance or capture.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - All dm_* outputs = 0.
  - wb_valid, wb_rdata, wb_type, wb_addr_lo = 0.
  - exc_valid, exc_code = 0.
- Reset in BUSY: dm_req drops immediately. The memory discards the access.
- Latency:
  - Acceptance cycle + N BUSY cycles (N ≥ 1, ending with dm_ready) + 1 RESP cycle.
  - stall is high for 1+N cycles.
- dm_req rises on the clock edge after acceptance. It falls on the edge after dm_ready.
- dm_ready outside BUSY is ignored.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after RESP. The minimum issue rate is one access per 3 cycles.

## Configuration
- Macro MEM_ALIGN_CHK_EN.
- When defined, the alignment check is active:
  - In IDLE, an access is misaligned if it is a halfword (H/HU) with addr[0]=1, or a word with addr[1:0]≠0.
  - A misaligned access issues no memory access and the FSM stays in IDLE.
  - exc_valid pulses for one cycle, combinationally with req_valid.
  - exc_code = 4 for a load, 5 for a store.
  - stall=0 in that cycle.
- When not defined:
  - exc_valid and exc_code are tied to 0.
  - Misaligned low address bits are ignored: a word access uses addr[31:2]; a halfword access uses addr[1].

## Structure
- State encoding (IDLE/BUSY/RESP) and the exception codes AdEL/AdES go into the shared head.v, next to the existing L_S_* constants.
- One sub-module: store_align. It is combinational: req_type, addr[1:0], wdata -> be, wdata_rep.
- The FSM and registers stay in mem_access_ctrl.

## Test plan
- Store byte: sb addr 0x0000_1003, wdata 0x0000_00AB, dm_ready in the first BUSY cycle -> dm_be = 4'b1000, dm_wdata = 0xABAB_ABAB, dm_addr = 0x400, stall high 2 cycles, wb_valid 1 cycle.
- Load half, slow memory: lh addr 0x0000_2002, dm_ready after 3 BUSY cycles, dm_rdata 0x8001_1234 -> stall high 4 cycles, wb_rdata = 0x8001_1234, wb_addr_lo = 2'b10, wb_type = `L_S_H`.
- Back-to-back lw: two lw to 0x0 then 0x4 -> second dm_req rises exactly 3 cycles after the first; no request is lost or duplicated.
- Misalignment: with MEM_ALIGN_CHK_EN, lw at 0x0000_1001 -> exc_valid = 1, exc_code = 4, dm_req stays 0. Without the macro, dm_addr = 0x400 and the access completes.
- Flush and reset:
  - flush with req_valid in IDLE -> no dm_req, stall = 0.
  - reset_n pulled low mid-BUSY -> dm_req = 0 before the next edge; FSM in IDLE after release.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// load/store access-type encodings, FSM states, address-error exception
// codes and the alignment rule used when MEM_ALIGN_CHK_EN is defined.
package mem_access_ctrl_pkg;

   // Load/store access size and sign encodings (L_S_*).
   localparam logic [2:0] L_S_B  = 3'b000;
   localparam logic [2:0] L_S_H  = 3'b001;
   localparam logic [2:0] L_S_W  = 3'b010;
   localparam logic [2:0] L_S_BU = 3'b100;
   localparam logic [2:0] L_S_HU = 3'b101;

   // Address-error exception codes.
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // A halfword must sit on an even address; a word on a multiple of four.
   function automatic logic is_misaligned(input logic [2:0] req_type,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if ((req_type == L_S_H || req_type == L_S_HU) && addr_lo[0])
         mis = 1'b1;
      if (req_type == L_S_W && addr_lo != 2'b00)
         mis = 1'b1;
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Store lane alignment: turns the access type and the low address bits into
// byte enables and replicates right-justified store data across all lanes.
// Unlisted access types produce no byte enables, so the memory writes nothing.
module store_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [2:0]  req_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep
);

   // Pick the lanes and replicate the data for byte, half and word stores.
   always_comb begin
      be        = 4'b0000;
      wdata_rep = 32'h0000_0000;
      case (req_type)
         L_S_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         L_S_H: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         L_S_W: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
         default: begin
            be        = 4'b0000;
            wdata_rep = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Accepts one load/store per
// instruction, runs a request/ready handshake with a variable-latency memory,
// stalls the pipeline until the access completes and hands the raw read word,
// access type and low address bits to the WB-stage load extension.
// Optional feature: define MEM_ALIGN_CHK_EN to raise AdEL/AdES on misaligned
// halfword/word accesses instead of issuing them.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [29:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ready,
   input  logic [31:0] dm_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_rdata,
   output logic [2:0]  wb_type,
   output logic [1:0]  wb_addr_lo,
   output logic        exc_valid,
   output logic [4:0]  exc_code
);

   state_t      state;
   state_t      state_next;
   logic        accept;
   logic        capture;
   logic        misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   store_align u_store_align (
      .req_type  (req_type),
      .addr_lo   (req_addr[1:0]),
      .wdata     (req_wdata),
      .be        (st_be),
      .wdata_rep (st_wdata)
   );

`ifdef MEM_ALIGN_CHK_EN
   assign misaligned = is_misaligned(req_type, req_addr[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   assign wb_valid = (state == RESP);

   // Next-state, stall, acceptance/capture strobes and the address-error pulse.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      exc_valid  = 1'b0;
      exc_code   = 5'd0;
      case (state)
         IDLE: begin
            if (req_valid && !flush) begin
               if (misaligned) begin
                  exc_valid = 1'b1;
                  exc_code  = req_we ? EXC_ADES : EXC_ADEL;
               end else begin
                  accept     = 1'b1;
                  stall      = 1'b1;
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (dm_ready) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Memory-side request registers: loaded at acceptance, request drops after ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_be    <= 4'b0000;
         dm_addr  <= 30'd0;
         dm_wdata <= 32'h0000_0000;
      end else if (accept) begin
         dm_req   <= 1'b1;
         dm_we    <= req_we;
         dm_be    <= req_we ? st_be : 4'b1111;
         dm_addr  <= req_addr[31:2];
         dm_wdata <= req_we ? st_wdata : 32'h0000_0000;
      end else if (capture) begin
         dm_req   <= 1'b0;
      end
   end

   // WB-side registers: type and low address at acceptance, read word on load completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_rdata   <= 32'h0000_0000;
         wb_type    <= 3'b000;
         wb_addr_lo <= 2'b00;
      end else begin
         if (accept) begin
            wb_type    <= req_type;
            wb_addr_lo <= req_addr[1:0];
         end
         if (capture && !dm_we)
            wb_rdata <= dm_rdata;
      end
   end

endmodule
